// File: rtl/sie_port_mux_n_if.sv
// Channel-side and SIE-side bundle for the N-way SIE port selector.
// slave: mux view (channels in, SIE out); master: the driving side.
interface sie_port_mux_n_if #(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8
);
  logic [SEL_W-1:0]         selReq;
  logic                     sieBusy;
  logic [NUM_CH*DATA_W-1:0] ctrlInFromCh;
  logic [NUM_CH*DATA_W-1:0] dataInFromCh;
  logic [NUM_CH-1:0]        wEnFromCh;
  logic [NUM_CH-1:0]        fullSpeedPolarityFromCh;
  logic [NUM_CH-1:0]        fullSpeedBitRateFromCh;
  logic [NUM_CH-1:0]        noActTimeOutEnFromCh;
  logic [DATA_W-1:0]        ctrlInToSIE;
  logic [DATA_W-1:0]        dataInToSIE;
  logic                     wEnToSIE;
  logic                     fullSpeedPolarityToSIE;
  logic                     fullSpeedBitRateToSIE;
  logic                     noActTimeOutEnToSIE;
  logic [SEL_W-1:0]         activeSel;
  logic                     switching;
  logic                     selErr;

  modport slave (
    input  selReq, sieBusy,
    input  ctrlInFromCh, dataInFromCh, wEnFromCh,
    input  fullSpeedPolarityFromCh,
    input  fullSpeedBitRateFromCh,
    input  noActTimeOutEnFromCh,
    output ctrlInToSIE, dataInToSIE, wEnToSIE,
    output fullSpeedPolarityToSIE,
    output fullSpeedBitRateToSIE,
    output noActTimeOutEnToSIE,
    output activeSel, switching, selErr
  );

  modport master (
    output selReq, sieBusy,
    output ctrlInFromCh, dataInFromCh, wEnFromCh,
    output fullSpeedPolarityFromCh,
    output fullSpeedBitRateFromCh,
    output noActTimeOutEnFromCh,
    input  ctrlInToSIE, dataInToSIE, wEnToSIE,
    input  fullSpeedPolarityToSIE,
    input  fullSpeedBitRateToSIE,
    input  noActTimeOutEnToSIE,
    input  activeSel, switching, selErr
  );
endinterface

// File: rtl/sie_port_mux_n.sv
// N-channel SIE port selector; switches only after drain + guard.
// Ports: usbClk, rstSyncToUsbClk (sync, high), bus (slave modport).
module sie_port_mux_n #(
  parameter int NUM_CH       = 2,
  parameter int SEL_W        = 3,
  parameter int DATA_W       = 8,
  parameter int GUARD_CYCLES = 4,
  parameter int DEFAULT_SEL  = 0
) (
  input  logic           usbClk,
  input  logic           rstSyncToUsbClk,
  sie_port_mux_n_if.slave bus
);

  localparam int CNT_W =
    (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    GUARD
  } state_t;

  state_t           state, stateNxt;
  logic [SEL_W-1:0] activeSel, activeSelNxt;
  logic [CNT_W-1:0] cnt, cntNxt;

  logic selLegal;
  logic selSame;

  logic [DATA_W-1:0] chCtrl, chData;
  logic chWEn, chPol, chRate, chNoAct;

  logic [DATA_W-1:0] ctrlNxt, dataNxt;
  logic wEnNxt, selErrNxt;

  assign selLegal = {1'b0, bus.selReq} < NCH;
  assign selSame  = bus.selReq == activeSel;

  always_ff @(posedge usbClk) begin
    if (rstSyncToUsbClk) begin
      state     <= ACTIVE;
      activeSel <= DEF_SEL;
      cnt       <= '0;
    end else begin
      state     <= stateNxt;
      activeSel <= activeSelNxt;
      cnt       <= cntNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    activeSelNxt = activeSel;
    cntNxt       = cnt;
    unique case (state)
      ACTIVE: begin
        if (selLegal && !selSame)
          stateNxt = DRAIN;
      end
      DRAIN: begin
        // Abort wins over a completed drain.
        if (!selLegal || selSame) begin
          stateNxt = ACTIVE;
        end else if (!bus.sieBusy) begin
          stateNxt     = GUARD;
          activeSelNxt = bus.selReq;
          cntNxt       = CNT_LOAD;
        end
      end
      GUARD: begin
        if (cnt == '0)
          stateNxt = ACTIVE;
        else
          cntNxt = cnt - 1'b1;
      end
      default: stateNxt = ACTIVE;
    endcase
  end

  always_comb begin
    chCtrl  = '0;
    chData  = '0;
    chWEn   = 1'b0;
    chPol   = 1'b0;
    chRate  = 1'b0;
    chNoAct = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (activeSel == SEL_W'(k)) begin
        chCtrl  = bus.ctrlInFromCh[k*DATA_W +: DATA_W];
        chData  = bus.dataInFromCh[k*DATA_W +: DATA_W];
        chWEn   = bus.wEnFromCh[k];
        chPol   = bus.fullSpeedPolarityFromCh[k];
        chRate  = bus.fullSpeedBitRateFromCh[k];
        chNoAct = bus.noActTimeOutEnFromCh[k];
      end
    end
  end

  // Config always tracks activeSel; in GUARD that is
  // already the new channel so the line settles early.
  always_comb begin
    ctrlNxt   = chCtrl;
    dataNxt   = chData;
    wEnNxt    = chWEn;
    selErrNxt = 1'b0;
    unique case (1'b1)
      state == ACTIVE: selErrNxt = !selLegal;
      state == DRAIN:  wEnNxt = 1'b0;
      state == GUARD: begin
        wEnNxt  = 1'b0;
        ctrlNxt = '0;
        dataNxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge usbClk) begin
    if (rstSyncToUsbClk) begin
      bus.ctrlInToSIE            <= '0;
      bus.dataInToSIE            <= '0;
      bus.wEnToSIE               <= 1'b0;
      bus.fullSpeedPolarityToSIE <= 1'b0;
      bus.fullSpeedBitRateToSIE  <= 1'b0;
      bus.noActTimeOutEnToSIE    <= 1'b0;
      bus.selErr                 <= 1'b0;
    end else begin
      bus.ctrlInToSIE            <= ctrlNxt;
      bus.dataInToSIE            <= dataNxt;
      bus.wEnToSIE               <= wEnNxt;
      bus.fullSpeedPolarityToSIE <= chPol;
      bus.fullSpeedBitRateToSIE  <= chRate;
      bus.noActTimeOutEnToSIE    <= chNoAct;
      bus.selErr                 <= selErrNxt;
    end
  end

  assign bus.activeSel = activeSel;
  assign bus.switching = state != ACTIVE;

endmodule

// File: tb/tb_sie_port_mux_n.sv
// Self-checking bench for sie_port_mux_n (3 channels).
// Random stimulus against a cycle-level behavioural model.
module tb_sie_port_mux_n;

  localparam int NUM_CH = 3;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 8;
  localparam int GUARD  = 4;
  localparam int DEF    = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sie_port_mux_n_if #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W)
  ) bus ();

  sie_port_mux_n #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W),
    .GUARD_CYCLES(GUARD), .DEFAULT_SEL(DEF)
  ) dut (
    .usbClk(clk),
    .rstSyncToUsbClk(rst),
    .bus(bus)
  );

  int   sel  = 0;
  logic busy = 1'b0;
  logic [7:0] ctrl [NUM_CH];
  logic [7:0] data [NUM_CH];
  logic wEn  [NUM_CH];
  logic pol  [NUM_CH];
  logic rate [NUM_CH];
  logic noa  [NUM_CH];

  always_comb begin
    bus.selReq  = SEL_W'(sel);
    bus.sieBusy = busy;
    for (int k = 0; k < NUM_CH; k++) begin
      bus.ctrlInFromCh[k*8 +: 8]       = ctrl[k];
      bus.dataInFromCh[k*8 +: 8]       = data[k];
      bus.wEnFromCh[k]                 = wEn[k];
      bus.fullSpeedPolarityFromCh[k]   = pol[k];
      bus.fullSpeedBitRateFromCh[k]    = rate[k];
      bus.noActTimeOutEnFromCh[k]      = noa[k];
    end
  end

  wire [23:0] obsV = {
    bus.ctrlInToSIE, bus.dataInToSIE, bus.wEnToSIE,
    bus.fullSpeedPolarityToSIE, bus.fullSpeedBitRateToSIE,
    bus.noActTimeOutEnToSIE, bus.activeSel,
    bus.switching, bus.selErr};

  int nCmp = 0;
  int nErr = 0;

  // Model: owner channel, mode (0 live, 1 draining,
  // 2 quiet) and quiet cycles still to go.
  int mOwner = DEF;
  int mMode  = 0;
  int mLeft  = 0;
  logic [23:0] expV = '0;

  task automatic rand_ch();
    for (int k = 0; k < NUM_CH; k++) begin
      ctrl[k] = 8'($urandom);
      data[k] = 8'($urandom);
      wEn[k]  = 1'($urandom);
      pol[k]  = 1'($urandom);
      rate[k] = 1'($urandom);
      noa[k]  = 1'($urandom);
    end
  endtask

  task automatic cycle();
    logic [7:0] eC, eD;
    logic eW, eE;
    int o;
    @(posedge clk);
    o = mOwner;
    if (rst) begin
      mOwner = DEF; mMode = 0; mLeft = 0;
      expV = {16'h0, 4'h0, 2'(DEF), 1'b0, 1'b0};
    end else begin
      eC = (mMode == 2) ? 8'h00 : ctrl[o];
      eD = (mMode == 2) ? 8'h00 : data[o];
      eW = (mMode == 0) ? wEn[o] : 1'b0;
      eE = (mMode == 0) && (sel >= NUM_CH);
      if (mMode == 0) begin
        if (sel < NUM_CH && sel != mOwner) mMode = 1;
      end else if (mMode == 1) begin
        if (sel >= NUM_CH || sel == mOwner) mMode = 0;
        else if (!busy) begin
          mOwner = sel; mMode = 2; mLeft = GUARD;
        end
      end else begin
        mLeft--;
        if (mLeft == 0) mMode = 0;
      end
      expV = {eC, eD, eW, pol[o], rate[o], noa[o],
              2'(mOwner), mMode != 0, eE};
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 0; busy = 1'b0;
    rand_ch();
    cycle();
    cycle();
    nCmp++;
    if (obsV !== 24'h0) begin
      nErr++;
      $display("FAIL reset_zero got=%h want=%h", obsV, 24'h0);
    end
    nCmp++;
    if (obsV !== expV) begin
      nErr++;
      $display("FAIL reset_model got=%h want=%h", obsV, expV);
    end
  endtask

  task automatic test_passthrough();
    rst = 1'b0;
    ctrl[0] = 8'hA5; data[0] = 8'h3C; wEn[0] = 1'b1;
    cycle();
    nCmp++;
    if ({bus.ctrlInToSIE, bus.dataInToSIE, bus.wEnToSIE}
        !== {8'hA5, 8'h3C, 1'b1}) begin
      nErr++;
      $display("FAIL pass_a5 got=%h/%h/%b want=a5/3c/1",
        bus.ctrlInToSIE, bus.dataInToSIE, bus.wEnToSIE);
    end
    for (int i = 0; i < 20; i++) begin
      rand_ch();
      cycle();
      nCmp++;
      if (obsV !== expV) begin
        nErr++;
        $display("FAIL pass_model cyc=%0d got=%h want=%h",
          i, obsV, expV);
      end
    end
  endtask

  task automatic test_switch();
    int sw = 0;
    rand_ch();
    ctrl[1] = 8'h5A; data[1] = 8'hC3; wEn[1] = 1'b1;
    sel = 1; busy = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (bus.switching) sw++;
      nCmp++;
      if (obsV !== expV) begin
        nErr++;
        $display("FAIL switch_model cyc=%0d got=%h want=%h",
          i, obsV, expV);
      end
      if (i >= 2 && i <= 6) begin
        nCmp++;
        if (bus.wEnToSIE !== 1'b0) begin
          nErr++;
          $display("FAIL switch_wen cyc=%0d got=%b want=0",
            i, bus.wEnToSIE);
        end
      end
    end
    nCmp++;
    if (sw !== 5) begin
      nErr++;
      $display("FAIL switch_len got=%0d want=5", sw);
    end
    nCmp++;
    if ({bus.ctrlInToSIE, bus.dataInToSIE, bus.wEnToSIE}
        !== {8'h5A, 8'hC3, 1'b1}) begin
      nErr++;
      $display("FAIL switch_live got=%h/%h/%b want=5a/c3/1",
        bus.ctrlInToSIE, bus.dataInToSIE, bus.wEnToSIE);
    end
  endtask

  task automatic test_drain_busy();
    int dr = 0;
    sel = 0; busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 11) busy = 1'b0;
      rand_ch();
      cycle();
      if (bus.switching && bus.activeSel == 2'd1) dr++;
      nCmp++;
      if (obsV !== expV) begin
        nErr++;
        $display("FAIL drain_model cyc=%0d got=%h want=%h",
          i, obsV, expV);
      end
    end
    nCmp++;
    if (dr !== 10) begin
      nErr++;
      $display("FAIL drain_len got=%0d want=10", dr);
    end
    nCmp++;
    if ({bus.activeSel, bus.switching} !== {2'd0, 1'b0}) begin
      nErr++;
      $display("FAIL drain_end got=%0d/%b want=0/0",
        bus.activeSel, bus.switching);
    end
  endtask

  task automatic test_abort();
    int moved = 0;
    rand_ch();
    wEn[0] = 1'b1; wEn[1] = 1'b0;
    sel = 1; busy = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) sel = 0;
      cycle();
      if (bus.activeSel !== 2'd0) moved++;
      nCmp++;
      if (obsV !== expV) begin
        nErr++;
        $display("FAIL abort_model cyc=%0d got=%h want=%h",
          i, obsV, expV);
      end
    end
    busy = 1'b0;
    nCmp++;
    if (moved !== 0) begin
      nErr++;
      $display("FAIL abort_sel got=%0d moves want=0", moved);
    end
    nCmp++;
    if ({bus.switching, bus.wEnToSIE} !== 2'b01) begin
      nErr++;
      $display("FAIL abort_wen got=%b/%b want=0/1",
        bus.switching, bus.wEnToSIE);
    end
  endtask

  task automatic test_sel_err();
    int errs = 0;
    int sws = 0;
    for (int i = 1; i <= 4; i++) begin
      sel = (i <= 2) ? 3 : 0;
      rand_ch();
      cycle();
      if (bus.selErr) errs++;
      if (bus.switching || bus.activeSel != 2'd0) sws++;
      nCmp++;
      if (obsV !== expV) begin
        nErr++;
        $display("FAIL selerr_model cyc=%0d got=%h want=%h",
          i, obsV, expV);
      end
    end
    nCmp++;
    if (errs !== 2) begin
      nErr++;
      $display("FAIL selerr_cnt got=%0d want=2", errs);
    end
    nCmp++;
    if (sws !== 0) begin
      nErr++;
      $display("FAIL selerr_state got=%0d want=0", sws);
    end
  endtask

  task automatic test_reset_guard();
    sel = 2; busy = 1'b0;
    rand_ch();
    for (int i = 0; i < 3; i++) cycle();
    nCmp++;
    if ({bus.activeSel, bus.switching} !== {2'd2, 1'b1}) begin
      nErr++;
      $display("FAIL rguard_pre got=%0d/%b want=2/1",
        bus.activeSel, bus.switching);
    end
    rst = 1'b1;
    cycle();
    nCmp++;
    if (obsV !== 24'h0) begin
      nErr++;
      $display("FAIL rguard_zero got=%h want=%h", obsV, 24'h0);
    end
    rst = 1'b0; sel = 0;
    rand_ch();
    cycle();
    nCmp++;
    if (obsV !== expV) begin
      nErr++;
      $display("FAIL rguard_model got=%h want=%h", obsV, expV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rand_ch();
      if ($urandom_range(0, 7) == 0) sel = $urandom_range(0, 3);
      busy = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      cycle();
      nCmp++;
      if (obsV !== expV) begin
        nErr++;
        $display("FAIL rand_model cyc=%0d got=%h want=%h",
          i, obsV, expV);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rand_ch();
    #1;
    test_reset();
    test_passthrough();
    test_switch();
    test_drain_busy();
    test_abort();
    test_sel_err();
    test_reset_guard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/sie_port_mux_n.md
Name: sie_port_mux_n

Overview:
- Parametrised N-channel successor to the two-way host/slave SIE port selector.
- Routes one of NUM_CH controller channels (host, slave, test/loopback engines) onto the single SIE port-control, data-write and line-config interface.
- Switches channel only at safe points: the in-flight SIE write is drained, then a guard interval holds the port quiet. The old mux switched combinationally and could glitch mid-transaction.
- Sits in the usbClk domain between the controller channels and the SIE.

Parameters:
- NUM_CH, 2: number of source channels (2..8).
- SEL_W, 3: width of the select request; must satisfy 2**SEL_W >= NUM_CH.
- DATA_W, 8: width of the port-control and port-data buses.
- GUARD_CYCLES, 4: quiet cycles after drain before the new channel is live (>=1).
- DEFAULT_SEL, 0: channel active out of reset (host = 0).

Ports:
- usbClk  in  1  clock; all logic on rising edge.
- rstSyncToUsbClk  in  1  synchronous, active-high reset.
- selReq  in  SEL_W  requested channel index, level-sensitive.
- sieBusy  in  1  SIE still processing a previous port write / transmit.
- ctrlInFromCh  in  NUM_CH*DATA_W  per-channel port-control bytes; channel k occupies [k*DATA_W +: DATA_W].
- dataInFromCh  in  NUM_CH*DATA_W  per-channel port-data bytes, same packing.
- wEnFromCh  in  NUM_CH  per-channel port write enable.
- fullSpeedPolarityFromCh  in  NUM_CH  per-channel line polarity.
- fullSpeedBitRateFromCh  in  NUM_CH  per-channel bit-rate select.
- noActTimeOutEnFromCh  in  NUM_CH  per-channel no-activity timeout enable.
- ctrlInToSIE  out  DATA_W  registered selected control.
- dataInToSIE  out  DATA_W  registered selected data.
- wEnToSIE  out  1  registered selected write enable.
- fullSpeedPolarityToSIE  out  1  registered.
- fullSpeedBitRateToSIE  out  1  registered.
- noActTimeOutEnToSIE  out  1  registered.
- activeSel  out  SEL_W  channel currently owning the SIE.
- switching  out  1  high while in DRAIN or GUARD.
- selErr  out  1  one-cycle pulse when selReq >= NUM_CH is seen in ACTIVE.

Behaviour:
- Reset (usbClk edge with rstSyncToUsbClk=1):
  - State is ACTIVE; activeSel=DEFAULT_SEL; guard counter=0.
  - All data outputs, switching and selErr are 0.
  - Reset mid-DRAIN/GUARD aborts the switch immediately.
- Latency: all SIE-side outputs are registered, 1 cycle from the channel inputs. There is no combinational path from any input to any output.
- ACTIVE:
  - Outputs follow channel activeSel.
  - If selReq == activeSel: no action.
  - If selReq < NUM_CH and selReq != activeSel: go to DRAIN next cycle.
  - If selReq >= NUM_CH: stay in ACTIVE and pulse selErr for 1 cycle. The pulse repeats each cycle while the illegal value is held.
- DRAIN:
  - wEnToSIE forced 0, so no new writes are accepted.
  - ctrl, data and config outputs keep following the old channel.
  - If selReq returns to activeSel (or becomes illegal): back to ACTIVE, no switch.
  - Otherwise, when sieBusy==0: latch the target channel into activeSel, load counter=GUARD_CYCLES-1, go to GUARD.
  - DRAIN has no timeout; the SIE guarantees sieBusy falls.
- GUARD:
  - wEnToSIE=0 and ctrlInToSIE=dataInToSIE=0.
  - Polarity, bit-rate and timeout-enable outputs already reflect the new activeSel, so line config settles before traffic.
  - Counter decrements each cycle; at counter==0 go to ACTIVE.
  - selReq changes are ignored in GUARD and re-evaluated in ACTIVE, so back-to-back requests give a full second switch.
- switching=1 exactly in DRAIN and GUARD.
- Switch duration: ACTIVE->ACTIVE is 1 + (drain wait) + GUARD_CYCLES cycles. With sieBusy=0 this is GUARD_CYCLES+2 cycles from the selReq edge to the first live output cycle.
- A write pulse on the target channel during DRAIN/GUARD is dropped, not queued. The channel must hold or retry until switching=0.
- Old-channel wEn asserted in the same cycle selReq changes is still forwarded, because the ACTIVE output register samples it.

Test Plan:
- Reset with DEFAULT_SEL=0, NUM_CH=2 -> activeSel=0, all outputs 0. One cycle after ch0 drives ctrl=0xA5, data=0x3C, wEn=1, outputs show 0xA5/0x3C/1.
- Switch 0->1, sieBusy=0, GUARD_CYCLES=4 -> switching high for 5 cycles. wEnToSIE=0 throughout; ctrl/data=0 during GUARD; ch1 values appear on the 6th cycle after the selReq edge (GUARD_CYCLES+2).
- Switch 0->1 with sieBusy held 10 cycles -> DRAIN for 10 cycles with ch0 config still driven. GUARD starts the cycle after sieBusy falls; activeSel changes at GUARD entry.
- Abort: selReq 0->1, then back to 0 during DRAIN -> return to ACTIVE, activeSel stays 0, no GUARD entered, ch0 wEn forwarded again.
- NUM_CH=3, SEL_W=2, selReq=3 held 2 cycles -> selErr high 2 cycles; state and activeSel unchanged.
- Reset asserted on the 2nd GUARD cycle -> next cycle state is ACTIVE, activeSel=DEFAULT_SEL, switching=0, outputs 0.
